keypad_digit_buffer: RTL and testbench

Downstream consumer of the keypad scanner: takes its registered one-hot 12-bit key code and `valid` strobe, and decodes each new press to a key value. Digits are accumulated in a 4-digit BCD entry buffer with clear/commit keys. The buffer is time-multiplexed onto a 4-digit common-cathode 7-segment display. Committed values are handed to the rest of the Keypad_Display design.

---
 rtl/keypad_digit_buffer.sv | 171 +++++++++++++++++
 tb/tb_keypad_digit_buffer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_digit_buffer.sv
// keypad_digit_buffer
//   Decodes one-hot key codes from the keypad scanner, accumulates up to four
//   BCD digits in an entry buffer ('*' clears, '#' commits) and multiplexes the
//   buffer onto a 4-digit common-cathode 7-segment display.
//
// Parameters
//   SCAN_DIV   clock cycles each display digit stays selected (>= 2)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   valid      key-held strobe from the scanner
//   Scan_out   one-hot key code: [8:0]='1'..'9', [9]='*', [10]='0', [11]='#'
//   value      last committed BCD value, digit 3 in [15:12]
//   commit     one-cycle pulse when value is loaded
//   key_err    one-cycle pulse when an accepted code is not one-hot
//   count      digits currently entered (0..4)
//   seg        {dp,g,f,e,d,c,b,a}, active-high, dp always 0
//   digit_sel  one-hot digit enable, bit 0 is the rightmost digit
//
// Build option
//   KEYPAD_BUF_BLANK_EN  when defined, positions >= count are blanked.

module keypad_digit_buffer #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [11:0] Scan_out,
    output logic [15:0] value,
    output logic        commit,
    output logic        key_err,
    output logic [2:0]  count,
    output logic [7:0]  seg,
    output logic [3:0]  digit_sel
);

    localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic {StIdle, StHeld} press_state_e;

    press_state_e press_state_q, press_state_d;
    logic         press;

    logic [15:0]     buf_q, buf_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [15:0]     value_q, value_d;
    logic            commit_q, commit_d;
    logic            err_q, err_d;
    logic [DivW-1:0] div_q, div_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      sel_q, sel_d;
    logic [7:0]      seg_q, seg_d;

    logic       code_onehot;
    logic [3:0] key_digit;
    logic       div_wrap;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'h3F;
            4'd1:    s = 8'h06;
            4'd2:    s = 8'h5B;
            4'd3:    s = 8'h4F;
            4'd4:    s = 8'h66;
            4'd5:    s = 8'h6D;
            4'd6:    s = 8'h7D;
            4'd7:    s = 8'h07;
            4'd8:    s = 8'h7F;
            4'd9:    s = 8'h6F;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    // Press detector: state register / next-state / output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) press_state_q <= StIdle;
        else      press_state_q <= press_state_d;
    end

    always_comb begin
        press_state_d = valid ? StHeld : StIdle;
    end

    always_comb begin
        press = valid && (press_state_q == StIdle);
    end

    // Key decode; only meaningful when the code is one-hot.
    always_comb begin
        code_onehot = (Scan_out != 12'd0) && ((Scan_out & (Scan_out - 12'd1)) == 12'd0);
        key_digit   = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (Scan_out[i]) key_digit = 4'(i + 1);
        end
    end

    // Entry buffer and commit path.
    always_comb begin
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        value_d  = value_q;
        commit_d = 1'b0;
        err_d    = 1'b0;
        if (press) begin
            if (!code_onehot) begin
                err_d = 1'b1;
            end else if (Scan_out[11]) begin
                value_d  = buf_q;
                commit_d = 1'b1;
                buf_d    = 16'd0;
                cnt_d    = 3'd0;
            end else if (Scan_out[9]) begin
                buf_d = 16'd0;
                cnt_d = 3'd0;
            end else begin
                // '0' is bit 10, for which key_digit stays 0.
                buf_d = {buf_q[11:0], key_digit};
                if (cnt_q < 3'd4) cnt_d = cnt_q + 3'd1;
            end
        end
    end

    // Display scan ring.
    always_comb begin
        div_wrap = (div_q == DivW'(SCAN_DIV - 1));
        div_d    = div_wrap ? '0 : div_q + DivW'(1);
        idx_d    = div_wrap ? idx_q + 2'd1 : idx_q;
        sel_d    = 4'b0001 << idx_d;
        // Decode from next-state buffer so seg tracks entry in the same edge.
        seg_d    = seg7(buf_d[{idx_d, 2'b00} +: 4]);
`ifdef KEYPAD_BUF_BLANK_EN
        if ({1'b0, idx_d} >= cnt_d) seg_d = 8'h00;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q    <= 16'd0;
            cnt_q    <= 3'd0;
            value_q  <= 16'd0;
            commit_q <= 1'b0;
            err_q    <= 1'b0;
            div_q    <= '0;
            idx_q    <= 2'd0;
            sel_q    <= 4'b0001;
            seg_q    <= 8'h00;
        end else begin
            buf_q    <= buf_d;
            cnt_q    <= cnt_d;
            value_q  <= value_d;
            commit_q <= commit_d;
            err_q    <= err_d;
            div_q    <= div_d;
            idx_q    <= idx_d;
            sel_q    <= sel_d;
            seg_q    <= seg_d;
        end
    end

    assign value     = value_q;
    assign commit    = commit_q;
    assign key_err   = err_q;
    assign count     = cnt_q;
    assign seg       = seg_q;
    assign digit_sel = sel_q;

endmodule

// File: tb/tb_keypad_digit_buffer.sv
// Self-checking bench for keypad_digit_buffer with SCAN_DIV=4.
module tb_keypad_digit_buffer;

    localparam int unsigned SCAN_DIV = 4;
`ifdef KEYPAD_BUF_BLANK_EN
    localparam logic [7:0] SegUnentered = 8'h00;
`else
    localparam logic [7:0] SegUnentered = 8'h3F;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic [11:0] scan_out = 12'd0;
    logic [15:0] value;
    logic        commit;
    logic        key_err;
    logic [2:0]  count;
    logic [7:0]  seg;
    logic [3:0]  digit_sel;

    int checks = 0;
    int errors = 0;

    keypad_digit_buffer #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .Scan_out  (scan_out),
        .value     (value),
        .commit    (commit),
        .key_err   (key_err),
        .count     (count),
        .seg       (seg),
        .digit_sel (digit_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [11:0] code, input int hold);
        scan_out = code;
        valid    = 1'b1;
        repeat (hold) tick();
        valid = 1'b0;
        tick();
    endtask

    // Waits for digit_sel to change into target, i.e. just after a divider wrap.
    task automatic wait_sel(input logic [3:0] target, input string tag);
        logic [3:0] prev;
        bit         hit;
        hit  = 1'b0;
        prev = digit_sel;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick();
            if (digit_sel == target && prev != target) hit = 1'b1;
            prev = digit_sel;
        end
        check(tag, {15'd0, hit}, 16'd1);
    endtask

    initial begin
        // Reset
        repeat (2) tick();
        check("rst_seg", {8'd0, seg}, 16'h0000);
        check("rst_sel", {12'd0, digit_sel}, 16'h0001);
        check("rst_count", {13'd0, count}, 16'd0);
        check("rst_value", value, 16'h0000);
        check("rst_commit", {15'd0, commit}, 16'd0);
        rst = 1'b1;
        tick();
        check("rel_seg", {8'd0, seg}, {8'd0, SegUnentered});
        tick(); tick();
        check("sel_hold", {12'd0, digit_sel}, 16'h0001);
        tick();
        check("sel_step1", {12'd0, digit_sel}, 16'h0002);
        repeat (4) tick();
        check("sel_step2", {12'd0, digit_sel}, 16'h0004);
        repeat (4) tick();
        check("sel_step3", {12'd0, digit_sel}, 16'h0008);
        repeat (4) tick();
        check("sel_wrap", {12'd0, digit_sel}, 16'h0001);

        // Entry: keys 1, 6, 0 -> buffer 0160
        press(12'h001, 5);
        press(12'h020, 5);
        press(12'h400, 5);
        check("entry_count", {13'd0, count}, 16'd3);
        wait_sel(4'b0100, "wait_d2");
        check("entry_d2", {8'd0, seg}, 16'h0006);
        wait_sel(4'b1000, "wait_d3");
        check("entry_d3", {8'd0, seg}, {8'd0, SegUnentered});
        wait_sel(4'b0001, "wait_d0");
        check("entry_d0", {8'd0, seg}, 16'h003F);
        wait_sel(4'b0010, "wait_d1");
        check("entry_d1", {8'd0, seg}, 16'h007D);

        // Commit after 1,2,3,4,5
        press(12'h001, 2);
        press(12'h002, 2);
        press(12'h004, 2);
        press(12'h008, 2);
        press(12'h010, 2);
        check("sat_count", {13'd0, count}, 16'd4);
        scan_out = 12'h800;
        valid    = 1'b1;
        tick();
        check("commit_pulse", {15'd0, commit}, 16'd1);
        check("commit_value", value, 16'h2345);
        check("commit_count", {13'd0, count}, 16'd0);
        tick();
        check("commit_drop", {15'd0, commit}, 16'd0);
        valid = 1'b0;
        tick();

        // Clear after 7,8
        press(12'h040, 2);
        press(12'h080, 2);
        check("clr_pre", {13'd0, count}, 16'd2);
        scan_out = 12'h200;
        valid    = 1'b1;
        tick();
        check("clr_count", {13'd0, count}, 16'd0);
        check("clr_commit", {15'd0, commit}, 16'd0);
        check("clr_value", value, 16'h2345);
        valid = 1'b0;
        tick();

        // Invalid codes
        scan_out = 12'h003;
        valid    = 1'b1;
        tick();
        check("err_multi", {15'd0, key_err}, 16'd1);
        check("err_count", {13'd0, count}, 16'd0);
        tick();
        check("err_drop", {15'd0, key_err}, 16'd0);
        valid = 1'b0;
        tick();
        scan_out = 12'h000;
        valid    = 1'b1;
        tick();
        check("err_zero", {15'd0, key_err}, 16'd1);
        valid = 1'b0;
        tick();

        // Hold '5' for 20 cycles while digit 0 is lit
        wait_sel(4'b0001, "wait_hold");
        scan_out = 12'h010;
        valid    = 1'b1;
        tick();
        check("hold_first", {13'd0, count}, 16'd1);
        check("hold_seg", {8'd0, seg}, 16'h006D);
        check("hold_err", {15'd0, key_err}, 16'd0);
        repeat (19) tick();
        check("hold_once", {13'd0, count}, 16'd1);
        valid = 1'b0;
        tick();

        // Back-to-back presses with a single idle cycle
        scan_out = 12'h020;
        valid    = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        valid = 1'b1;
        tick();
        check("b2b_count", {13'd0, count}, 16'd3);
        valid = 1'b0;
        tick();
        press(12'h020, 2);
        press(12'h020, 2);
        check("sat_again", {13'd0, count}, 16'd4);
        press(12'h800, 1);
        check("commit_6666", value, 16'h6666);

        // '#' with empty buffer
        scan_out = 12'h800;
        valid    = 1'b1;
        tick();
        check("zero_commit", {15'd0, commit}, 16'd1);
        check("zero_value", value, 16'h0000);
        valid = 1'b0;
        tick();
        press(12'h001, 2);
        press(12'h020, 2);
        press(12'h800, 2);
        check("commit_16", value, 16'h0016);

        // Asynchronous reset between clock edges
        press(12'h008, 2);
        check("ar_pre", {13'd0, count}, 16'd1);
        #2;
        rst = 1'b0;
        #1;
        check("ar_count", {13'd0, count}, 16'd0);
        check("ar_value", value, 16'h0000);
        check("ar_seg", {8'd0, seg}, 16'h0000);
        check("ar_sel", {12'd0, digit_sel}, 16'h0001);
        tick();
        rst = 1'b1;
        tick();
        check("ar_after", {13'd0, count}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
